// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory bank: access-size codes, FSM states, lane helper.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_t;

  // Number of byte lanes touched by an access of the given size; 0 for the reserved code.
  function automatic int lane_count(input logic [1:0] sz, input int word_lanes);
    case (sz)
      SZ_BYTE: return 1;
      SZ_HALF: return 2;
      SZ_WORD: return word_lanes;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load aligner: picks the addressed lanes out of a memory word, right-aligns and extends them.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
module dmem_load_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LANE_W = 2
) (
  input  logic [DATA_W-1:0] word,
  input  logic [LANE_W-1:0] lane,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;
  logic              sext;
  int                nbits;

  // Shift the addressed lane down to bit 0, then fill everything above the access width with the extension bit.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    nbits   = 8 * lane_count(size, DATA_W / 8);
    sext    = 1'b0;
    data    = '0;
    if (nbits > 0) begin
      sext = ~unsigned_ld & shifted[nbits-1];
      for (int b = 0; b < DATA_W; b++) begin
        data[b] = (b < nbits) ? shifted[b] : sext;
      end
    end
  end

endmodule

// File: rtl/data_mem_bank.sv
// Byte-addressable data memory with sub-word stores/loads, alignment and range faulting; DATA_MEM_BANK_INIT_EN adds a post-reset fill memory[i]=i.
// Latency: stores commit at the accepting edge; load data, rvalid and fault appear one cycle after acceptance.
// Backpressure: ready is low only while the optional init fill runs; requests seen while ready is low are dropped.
module data_mem_bank
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [1:0]        size,
  input  logic              unsigned_ld,
  input  logic [DATA_W-1:0] writedata,
  output logic [DATA_W-1:0] readdata,
  output logic              rvalid,
  output logic              fault,
  output logic              ready
);

  localparam int LANES  = DATA_W / 8;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state;
  state_t            state_nxt;

  logic [ADDR_W-1:0] word_idx;
  logic [LANE_W-1:0] lane;
  logic [IDX_W-1:0]  idx;
  int                nlanes;
  logic              bad;
  logic              accept;
  logic              do_write;
  logic              do_read;
  logic              do_fault;
  logic [LANES-1:0]  lane_we;
  logic [DATA_W-1:0] wdata_sh;
  logic [DATA_W-1:0] ld_data;

  assign ready = (state == ST_IDLE);

  // Decode the request: word/lane split, legality, and which lanes a store touches.
  always_comb begin
    word_idx = addr >> LANE_W;
    lane     = addr[LANE_W-1:0];
    idx      = word_idx[IDX_W-1:0];
    nlanes   = lane_count(size, LANES);
    // Full-width range compare so upper address bits fault instead of aliasing.
    bad      = (size == 2'b11)
             || ((size == SZ_HALF) && addr[0])
             || ((size == SZ_WORD) && (lane != '0))
             || (word_idx >= DEPTH_A);
    accept   = ready && !rst && (MemWrite || MemRead);
    do_write = accept && MemWrite && !bad;
    do_read  = accept && MemRead && !MemWrite && !bad;
    do_fault = accept && bad;
    wdata_sh = writedata << {lane, 3'b000};
    lane_we  = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_we[l] = do_write && (l >= int'(lane)) && (l < int'(lane) + nlanes);
    end
  end

`ifdef DATA_MEM_BANK_INIT_EN
  logic [IDX_W-1:0] init_cnt;
  logic [IDX_W-1:0] init_cnt_nxt;
  logic             init_wr;

  // State and fill counter; reset restarts the fill from word 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_INIT;
      init_cnt <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= init_cnt_nxt;
    end
  end

  // Walk the fill counter one word per cycle, leaving INIT after the last word.
  always_comb begin
    state_nxt    = state;
    init_cnt_nxt = init_cnt;
    init_wr      = 1'b0;
    case (state)
      ST_INIT: begin
        init_wr      = 1'b1;
        init_cnt_nxt = init_cnt + 1'b1;
        if (init_cnt == IDX_W'(DEPTH - 1)) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end
`else
  // Without the fill there is nothing to wait for: reset lands straight in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // IDLE is the only reachable state in this build.
  always_comb begin
    state_nxt = ST_IDLE;
  end
`endif

  // Storage: init fill or per-lane store; nothing is written while rst is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
`ifdef DATA_MEM_BANK_INIT_EN
      if (init_wr) begin
        mem[init_cnt] <= DATA_W'(init_cnt);
      end
`endif
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) begin
          mem[idx][l*8 +: 8] <= wdata_sh[l*8 +: 8];
        end
      end
    end
  end

  dmem_load_align #(
    .DATA_W (DATA_W),
    .LANE_W (LANE_W)
  ) u_align (
    .word        (mem[idx]),
    .lane        (lane),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .data        (ld_data)
  );

  // Response register: load data only on an accepted read, otherwise zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      readdata <= '0;
      rvalid   <= 1'b0;
      fault    <= 1'b0;
    end else begin
      readdata <= do_read ? ld_data : '0;
      rvalid   <= do_read;
      fault    <= do_fault;
    end
  end

endmodule

// File: tb/tb_data_mem_bank.sv
module tb_data_mem_bank;
  import dmem_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 32;
`ifdef DATA_MEM_BANK_INIT_EN
  localparam int READY_LAT = DEPTH;
  localparam logic RST_READY = 1'b0;
`else
  localparam int READY_LAT = 0;
  localparam logic RST_READY = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [ADDR_W-1:0] addr = '0;
  logic              MemWrite = 1'b0;
  logic              MemRead = 1'b0;
  logic [1:0]        size = 2'b00;
  logic              unsigned_ld = 1'b0;
  logic [DATA_W-1:0] writedata = '0;
  logic [DATA_W-1:0] readdata;
  logic              rvalid;
  logic              fault;
  logic              ready;

  always #5 clk = ~clk;

  data_mem_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .addr(addr), .MemWrite(MemWrite), .MemRead(MemRead),
    .size(size), .unsigned_ld(unsigned_ld), .writedata(writedata),
    .readdata(readdata), .rvalid(rvalid), .fault(fault), .ready(ready)
  );

  typedef struct packed {
    logic        rv;
    logic        ft;
    logic [31:0] rd;
  } exp_t;

  exp_t       q[$];
  int         tests = 0;
  int         fails = 0;
  bit         mon_en = 1'b0;
  logic [7:0] mem_m [DEPTH*4];

  // Monitor: every cycle after an issued request pops its expectation and compares.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        tests++;
        if ({rvalid, fault, readdata} !== e) begin
          fails++;
          $display("FAIL resp t=%0t: got rvalid=%0b fault=%0b readdata=%h, want rvalid=%0b fault=%0b readdata=%h",
                   $time, rvalid, fault, readdata, e.rv, e.ft, e.rd);
        end
      end else begin
        tests++;
        if (rvalid !== 1'b0 || fault !== 1'b0) begin
          fails++;
          $display("FAIL spurious t=%0t: got rvalid=%0b fault=%0b, want 0 0", $time, rvalid, fault);
        end
      end
    end
  end

  task automatic idle();
    MemWrite = 1'b0; MemRead = 1'b0; addr = '0; size = 2'b00; unsigned_ld = 1'b0; writedata = '0;
  endtask

  // Drive one request and push the response the byte-level reference model predicts.
  task automatic issue(input logic [31:0] a, input logic w, input logic r, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd, input bit use_lit, input logic [31:0] lit);
    exp_t        e;
    int          nb;
    bit          bad;
    logic [31:0] v;
    @(negedge clk);
    addr = a; MemWrite = w; MemRead = r; size = sz; unsigned_ld = u; writedata = wd;
    e  = '0;
    nb = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    if (w || r) begin
      bad = (sz == 2'b11) || (a % nb != 0) || (a / 4 >= DEPTH);
      if (bad) begin
        e.ft = 1'b1;
      end else if (w) begin
        for (int k = 0; k < nb; k++) mem_m[a + k] = wd[8*k +: 8];
      end else begin
        v = '0;
        for (int k = 0; k < nb; k++) v = v | (32'(mem_m[a + k]) << (8 * k));
        if (nb < 4 && !u && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
        e.rv = 1'b1;
        e.rd = use_lit ? lit : v;
      end
    end
    q.push_back(e);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(posedge clk); #2;
      guard++;
    end
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses outstanding, want 0", q.size());
    end
  endtask

  // Reset with a competing request, optionally re-reset partway through, then time the ready rise.
  task automatic do_reset(input int glitch);
    int n;
    drain();
    @(negedge clk);
    rst = 1'b1; addr = '0; MemWrite = 1'b1; MemRead = 1'b1; size = SZ_WORD; writedata = 32'hDEAD_BEEF;
    @(posedge clk); #2;
    mon_en = 1'b1;
    tests++;
    if (readdata !== '0 || rvalid !== 1'b0 || fault !== 1'b0 || ready !== RST_READY) begin
      fails++;
      $display("FAIL reset_state: got readdata=%h rvalid=%0b fault=%0b ready=%0b, want 0 0 0 %0b",
               readdata, rvalid, fault, ready, RST_READY);
    end
    @(negedge clk);
    rst = 1'b0;
    // Keep a write request pending only while the bank is guaranteed not ready.
    if (ready === 1'b1) idle();
    if (glitch > 0) begin
      repeat (glitch) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
    n = 0;
    while (ready !== 1'b1 && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
    idle();
    tests++;
    if (n != READY_LAT) begin
      fails++;
      $display("FAIL ready_latency: got %0d cycles not ready, want %0d", n, READY_LAT);
    end
`ifdef DATA_MEM_BANK_INIT_EN
    for (int i = 0; i < DEPTH * 4; i++) mem_m[i] = (i % 4 == 0) ? 8'(i / 4) : 8'h00;
`else
    for (int i = 0; i < DEPTH; i++) issue(32'(i * 4), 1'b1, 1'b0, SZ_WORD, 1'b0, $urandom, 1'b0, '0);
`endif
  endtask

  task automatic random_ops(input int count);
    for (int i = 0; i < count; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      logic [1:0]  op;
      int          sel;
      sz  = 2'($urandom_range(0, 3));
      op  = 2'($urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = $urandom_range(DEPTH * 4, DEPTH * 4 + 15);
      else begin
        a = $urandom_range(0, DEPTH * 4 - 1);
        if (sel > 3) a = (sz == SZ_HALF) ? (a & ~32'd1) : (sz == SZ_WORD) ? (a & ~32'd3) : a;
      end
      issue(a, op[0], op[1], sz, 1'($urandom_range(0, 1)), $urandom, 1'b0, '0);
    end
  endtask

  initial begin
    do_reset(0);
`ifdef DATA_MEM_BANK_INIT_EN
    issue(32'h14, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'd5);
    issue(32'h00, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'd0);
`endif
    issue(32'h08, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'hAABB_CCDD, 1'b0, '0);
    issue(32'h09, 1'b0, 1'b1, SZ_BYTE, 1'b0, '0, 1'b1, 32'hFFFF_FFCC);
    issue(32'h09, 1'b0, 1'b1, SZ_BYTE, 1'b1, '0, 1'b1, 32'h0000_00CC);
    issue(32'h0A, 1'b0, 1'b1, SZ_HALF, 1'b0, '0, 1'b1, 32'hFFFF_AABB);
    issue(32'h0A, 1'b0, 1'b1, SZ_HALF, 1'b1, '0, 1'b1, 32'h0000_AABB);
    issue(32'h0B, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h0000_0011, 1'b0, '0);
    issue(32'h08, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'h11BB_CCDD);
    issue(32'h06, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b0, '0);
    issue(32'h03, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_5555, 1'b0, '0);
    issue(32'h08, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'h11BB_CCDD);
    issue(32'h04, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b0, '0);
    issue(32'h80, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b0, '0);
    issue(32'h8000_0008, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h0BAD_0BAD, 1'b0, '0);
    issue(32'h08, 1'b0, 1'b1, 2'b11, 1'b0, '0, 1'b0, '0);
    issue(32'h08, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'h11BB_CCDD);
    issue(32'h00, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h0000_1234, 1'b0, '0);
    issue(32'h00, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'h0000_1234);
    issue(32'h02, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h0000_BEEF, 1'b0, '0);
    issue(32'h00, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'hBEEF_1234);
    issue(32'h03, 1'b0, 1'b1, SZ_BYTE, 1'b0, '0, 1'b1, 32'hFFFF_FFBE);
    issue(32'h00, 1'b0, 1'b0, SZ_WORD, 1'b0, '0, 1'b0, '0);
    random_ops(400);

    do_reset(10);
`ifdef DATA_MEM_BANK_INIT_EN
    issue(32'h7C, 1'b0, 1'b1, SZ_WORD, 1'b0, '0, 1'b1, 32'd31);
`endif
    random_ops(150);
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    fails++;
    $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
